pred16_gen: RTL and testbench

- Intra 16x16 prediction generator. Sits directly upstream of the 16x16 residual stage and produces the vertical, horizontal and DC prediction blocks that stage subtracts from the macroblock.
- Accepts 32 neighbour samples serially: 16 top, then 16 left. Computes the DC value, then streams the three predictions one row per beat.

---
 rtl/pred16_gen.sv | 153 +++++++++++++++
 tb/tb_pred16_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pred16_gen.sv
// pred16_gen: intra 16x16 vertical/horizontal/DC prediction generator.
// Define PRED16_DC_OUT_EN to expose dc_val, sum_top and sum_left.
module pred16_gen #(
  parameter int BW         = 8,
  parameter int DC_DEFAULT = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            start,
  input  logic            top_avail,
  input  logic            left_avail,
  input  logic            nb_valid,
  output logic            nb_ready,
  input  logic [BW-1:0]   nb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_row,
  output logic            out_last,
  output logic [16*BW-1:0] vpred_row,
  output logic [16*BW-1:0] hpred_row,
  output logic [16*BW-1:0] dcpred_row,
  output logic [2:0]      mode_avail,
  output logic            busy,
  output logic            done
`ifdef PRED16_DC_OUT_EN
  ,
  output logic [BW-1:0]   dc_val,
  output logic [BW+3:0]   sum_top,
  output logic [BW+3:0]   sum_left
`endif
);

  typedef enum logic [1:0] {
    IDLE, LOAD, CALC, EMIT
  } state_t;

  localparam logic [BW-1:0] DEF = BW'(DC_DEFAULT);

  state_t          state, state_nx;
  logic [BW-1:0]   top_mem  [16];
  logic [BW-1:0]   left_mem [16];
  logic [BW+3:0]   sum_t, sum_l;
  logic [BW+5:0]   sum_all;
  logic [4:0]      cnt;
  logic [3:0]      row;
  logic [BW-1:0]   dc, dc_nx;
  logic            top_q, left_q, mode_q;
  logic            st_go, nb_fire, out_fire, last_fire;
  logic            emit;

  assign emit      = (state == EMIT);
  assign st_go     = enable & start & (state == IDLE);
  assign nb_fire   = enable & nb_valid & (state == LOAD);
  assign out_fire  = enable & out_ready & emit;
  assign last_fire = out_fire & (row == 4'd15);

  // Next-state selection; everything holds while enable is low.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (st_go) state_nx = LOAD;
      LOAD: if (nb_fire && cnt == 5'd31) state_nx = CALC;
      CALC: if (enable) state_nx = EMIT;
      EMIT: if (last_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // DC value from whichever edges were flagged available at start.
  always_comb begin
    sum_all = {2'b00, sum_t} + {2'b00, sum_l} + (BW+6)'(16);
    dc_nx   = DEF;
    unique case ({top_q, left_q})
      2'b11: dc_nx = BW'(sum_all >> 5);
      2'b10: dc_nx = BW'((sum_t + (BW+4)'(8)) >> 4);
      2'b01: dc_nx = BW'((sum_l + (BW+4)'(8)) >> 4);
      2'b00: dc_nx = DEF;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Sample storage, sums, counters, DC and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        top_mem[i]  <= '0;
        left_mem[i] <= '0;
      end
      sum_t  <= '0;
      sum_l  <= '0;
      cnt    <= '0;
      row    <= '0;
      dc     <= '0;
      top_q  <= 1'b0;
      left_q <= 1'b0;
      mode_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last_fire;
      if (st_go) begin
        top_q  <= top_avail;
        left_q <= left_avail;
        mode_q <= 1'b1;
        sum_t  <= '0;
        sum_l  <= '0;
        cnt    <= '0;
      end
      if (nb_fire) begin
        cnt <= cnt + 5'd1;
        if (!cnt[4]) begin
          top_mem[cnt[3:0]] <= nb_data;
          sum_t <= sum_t + (BW+4)'(nb_data);
        end else begin
          left_mem[cnt[3:0]] <= nb_data;
          sum_l <= sum_l + (BW+4)'(nb_data);
        end
      end
      if (state == CALC && enable) begin
        dc  <= dc_nx;
        row <= '0;
      end
      if (out_fire) row <= row + 4'd1;
    end
  end

  assign nb_ready   = enable & (state == LOAD);
  assign out_valid  = enable & emit;
  assign out_row    = emit ? row : 4'd0;
  assign out_last   = emit & (row == 4'd15);
  assign busy       = (state != IDLE);
  assign mode_avail = {mode_q, left_q, top_q};

  for (genvar x = 0; x < 16; x++) begin : g_px
    assign vpred_row[x*BW +: BW] =
      !emit ? '0 : (top_q ? top_mem[x] : DEF);
    assign hpred_row[x*BW +: BW] =
      !emit ? '0 : (left_q ? left_mem[row] : DEF);
    assign dcpred_row[x*BW +: BW] = emit ? dc : '0;
  end

`ifdef PRED16_DC_OUT_EN
  assign dc_val   = dc;
  assign sum_top  = sum_t;
  assign sum_left = sum_l;
`endif

endmodule

// File: tb/tb_pred16_gen.sv
// tb_pred16_gen: scoreboard bench for pred16_gen.
// Directed edge patterns, stalls, enable freeze and mid-emit reset.
`timescale 1ns/1ps
module tb_pred16_gen;
  localparam int BW = 8;
  localparam int RW = 16*BW;

  typedef struct packed {
    logic [3:0]    row;
    logic          last;
    logic [2:0]    mode;
    logic [RW-1:0] v;
    logic [RW-1:0] h;
    logic [RW-1:0] d;
  } exp_t;

  logic clk = 0;
  logic reset = 0;
  logic enable = 1;
  logic start = 0;
  logic top_avail = 0;
  logic left_avail = 0;
  logic nb_valid = 0;
  logic out_ready = 1;
  logic [BW-1:0] nb_data = '0;
  logic nb_ready, out_valid, out_last, busy, done;
  logic [3:0] out_row;
  logic [RW-1:0] vpred_row, hpred_row, dcpred_row;
  logic [2:0] mode_avail;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int rdy_k = 0;
  logic [BW-1:0] tv[16];
  logic [BW-1:0] lv[16];
  logic [3:0] pat = 4'b1001;

  pred16_gen #(.BW(BW), .DC_DEFAULT(128)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .top_avail(top_avail), .left_avail(left_avail),
    .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_data(nb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_last(out_last),
    .vpred_row(vpred_row), .hpred_row(hpred_row),
    .dcpred_row(dcpred_row), .mode_avail(mode_avail),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: always, 1-0-0-1 pattern, or stall on row 7.
  always @(negedge clk) begin
    case (rdy_mode)
      1: out_ready = pat[rdy_k % 4];
      2: out_ready = !(out_valid && out_row == 4'd7);
      default: out_ready = 1'b1;
    endcase
    rdy_k++;
  end

  logic          stalled = 0;
  logic [3:0]    s_row;
  logic [RW-1:0] s_v, s_h, s_d;

  // Monitor: pops and compares each beat about to be accepted.
  always @(negedge clk) begin
    #1;
    if (stalled && out_valid) begin
      chk("hold_row", out_row, s_row);
      chk("hold_v", vpred_row, s_v);
      chk("hold_h", hpred_row, s_h);
      chk("hold_dc", dcpred_row, s_d);
    end
    stalled = 0;
    if (out_valid && !out_ready) begin
      stalled = 1;
      s_row = out_row;
      s_v = vpred_row;
      s_h = hpred_row;
      s_d = dcpred_row;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got row %0d expected none",
                 out_row);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("row", out_row, e.row);
        chk("last", out_last, e.last);
        chk("mode", mode_avail, e.mode);
        chk("vpred", vpred_row, e.v);
        chk("hpred", hpred_row, e.h);
        chk("dcpred", dcpred_row, e.d);
      end
    end
  end

  task automatic kick(input logic t, input logic l);
    @(negedge clk);
    start = 1;
    top_avail = t;
    left_avail = l;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push_exp(input logic t, input logic l,
                          input logic [BW-1:0] dc);
    for (int y = 0; y < 16; y++) begin
      exp_t e;
      e.row = 4'(y);
      e.last = (y == 15);
      e.mode = {1'b1, l, t};
      for (int x = 0; x < 16; x++) begin
        e.v[x*BW +: BW] = t ? tv[x] : 8'd128;
        e.h[x*BW +: BW] = l ? lv[y] : 8'd128;
        e.d[x*BW +: BW] = dc;
      end
      q.push_back(e);
    end
  endtask

  task automatic send(input int pause_at);
    int i = 0;
    int n = 0;
    bit paused = 0;
    while (i < 32 && n < 1000) begin
      @(negedge clk);
      nb_valid = 1;
      nb_data = (i < 16) ? tv[i] : lv[i-16];
      if (i == pause_at && !paused) begin
        paused = 1;
        enable = 0;
        repeat (5) begin
          #2;
          chk("nb_ready_frozen", nb_ready, 0);
          @(negedge clk);
        end
        enable = 1;
      end
      #1;
      if (nb_ready) i++;
      n++;
    end
    if (i < 32) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got %0d samples expected 32", i);
    end
    @(negedge clk);
    nb_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      #2;
      n++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done expected pulse");
    end else begin
      chk("done_busy", busy, 0);
      chk("done_valid", out_valid, 0);
      chk("queue_empty", q.size(), 0);
      @(negedge clk);
      #2;
      chk("done_width", done, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nb_ready", nb_ready, 0);
    chk("rst_mode", mode_avail, 0);
    chk("rst_v", vpred_row, 0);
    chk("rst_h", hpred_row, 0);
    chk("rst_dc", dcpred_row, 0);
    reset = 1;

    // Both edges: dc = (120+376+16)>>5 = 16.
    for (int x = 0; x < 16; x++) begin
      tv[x] = 8'(x);
      lv[x] = 8'(16 + x);
    end
    kick(1, 1);
    push_exp(1, 1, 8'd16);
    send(-1);
    wait_done();

    // Top only with 1,0,0,1 ready pattern: dc = 200, h = 128.
    rdy_mode = 1;
    for (int x = 0; x < 16; x++) begin
      tv[x] = 8'd200;
      lv[x] = 8'd7;
    end
    kick(1, 0);
    push_exp(1, 0, 8'd200);
    send(-1);
    wait_done();
    rdy_mode = 0;

    // Neither edge: everything 128.
    for (int x = 0; x < 16; x++) begin
      tv[x] = 8'(x * 3);
      lv[x] = 8'(255 - x);
    end
    kick(0, 0);
    push_exp(0, 0, 8'd128);
    send(-1);
    wait_done();

    // Left only: dc = (120+8)>>4 = 8, v = 128.
    for (int x = 0; x < 16; x++) lv[x] = 8'(x);
    kick(0, 1);
    push_exp(0, 1, 8'd8);
    send(-1);
    wait_done();

    // Enable frozen for 5 cycles after 20 samples.
    for (int x = 0; x < 16; x++) begin
      tv[x] = 8'(x);
      lv[x] = 8'(16 + x);
    end
    kick(1, 1);
    push_exp(1, 1, 8'd16);
    send(20);
    wait_done();

    // Reset while row 7 is presented.
    for (int x = 0; x < 16; x++) begin
      tv[x] = 8'd10;
      lv[x] = 8'd20;
    end
    rdy_mode = 2;
    kick(1, 1);
    push_exp(1, 1, 8'd15);
    send(-1);
    begin
      int n = 0;
      bit hit = 0;
      while (!hit && n < 300) begin
        @(negedge clk);
        #2;
        n++;
        if (out_valid && out_row == 4'd7) hit = 1;
      end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL row7_timeout: got no row 7 expected row 7");
      end
    end
    #1;
    reset = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mode", mode_avail, 0);
    chk("rows_before_rst", q.size(), 9);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("mid_rst_no_done", done, 0);
    end
    rdy_mode = 0;
    reset = 1;
    @(negedge clk);
    #2;
    chk("post_rst_no_done", done, 0);

    // Clean reload after reset: dc = (160+320+16)>>5 = 15.
    kick(1, 1);
    push_exp(1, 1, 8'd15);
    send(-1);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
